// File: rtl/falafel_mem_arbiter.sv
// rtl/falafel_mem_arbiter.sv - round-robin arbiter sharing one memory port among NUM_REQ requesters
// Responses return in request order and are routed back via a queue of grant indices.

package falafel_pkg;
   localparam int DATA_W = 16;
endpackage

module falafel_mem_arbiter
   import falafel_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NUM_REQ-1:0]                req_val_i,
   output logic [NUM_REQ-1:0]                req_rdy_o,
   input  logic [NUM_REQ-1:0]                req_is_write_i,
   input  logic [NUM_REQ*DATA_W-1:0]         req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0]         req_data_i,
   output logic [NUM_REQ-1:0]                rsp_val_o,
   input  logic [NUM_REQ-1:0]                rsp_rdy_i,
   output logic [DATA_W-1:0]                 rsp_data_o,
   output logic                              mem_req_val_o,
   input  logic                              mem_req_rdy_i,
   output logic                              mem_req_is_write_o,
   output logic [DATA_W-1:0]                 mem_req_addr_o,
   output logic [DATA_W-1:0]                 mem_req_data_o,
   input  logic                              mem_rsp_val_i,
   output logic                              mem_rsp_rdy_o,
   input  logic [DATA_W-1:0]                 mem_rsp_data_i,
   output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = PTR_W + 1;

   logic [IDX_W-1:0] rr_q, rr_d;
   logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
   logic             lock_q, lock_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] order_q [MAX_OUTSTANDING];

   logic [IDX_W-1:0] grant;
   logic [IDX_W-1:0] scan_idx;
   logic             found;
   logic [IDX_W-1:0] head;
   logic             any_val;
   logic             q_full;
   logic             q_empty;
   logic             push;
   logic             pop;

   assign any_val = |req_val_i;
   assign q_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
   assign q_empty = (count_q == '0);
   assign head    = order_q[rd_ptr_q];

   // A stalled request keeps its grant so the payload seen by memory cannot change under it.
   always_comb begin
      grant    = rr_q;
      scan_idx = rr_q;
      found    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = IDX_W'((int'(rr_q) + i) % NUM_REQ);
         if (!found && req_val_i[scan_idx]) begin
            grant = scan_idx;
            found = 1'b1;
         end
      end
      if (lock_q) begin
         grant = lock_idx_q;
      end
   end

   assign mem_req_val_o      = !rst_i && any_val && !q_full;
   assign mem_req_is_write_o = req_is_write_i[grant];
   assign mem_req_addr_o     = req_addr_i[int'(grant)*DATA_W +: DATA_W];
   assign mem_req_data_o     = req_data_i[int'(grant)*DATA_W +: DATA_W];

   always_comb begin
      req_rdy_o        = '0;
      req_rdy_o[grant] = !rst_i && mem_req_rdy_i && !q_full;
   end

   always_comb begin
      rsp_val_o       = '0;
      rsp_val_o[head] = !rst_i && mem_rsp_val_i && !q_empty;
   end

   assign mem_rsp_rdy_o = !rst_i && !q_empty && rsp_rdy_i[head];
   assign rsp_data_o    = mem_rsp_data_i;
   assign outstanding_o = rst_i ? '0 : count_q;

   assign push = mem_req_val_o && mem_req_rdy_i;
   assign pop  = mem_rsp_val_i && mem_rsp_rdy_o;

   always_comb begin
      rr_d       = rr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (push) begin
         rr_d   = IDX_W'((int'(grant) + 1) % NUM_REQ);
         lock_d = 1'b0;
      end else if (mem_req_val_o) begin
         lock_d     = 1'b1;
         lock_idx_d = grant;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q       <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         rr_q       <= rr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Entries beyond the pointers are dead, so the storage itself needs no reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         order_q[wr_ptr_q] <= grant;
      end
   end

endmodule

// File: tb/tb_falafel_mem_arbiter.sv
// tb/tb_falafel_mem_arbiter.sv - self-checking bench for falafel_mem_arbiter
// A queue-based reference model is checked every cycle, plus directed literal checks.

module tb_falafel_mem_arbiter;
   import falafel_pkg::*;

   localparam int N  = 2;
   localparam int MO = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_val, req_rdy, req_wr, rsp_val, rsp_rdy;
   logic [N*DATA_W-1:0] req_addr, req_data;
   logic [DATA_W-1:0] rsp_data;
   logic              mem_req_val, mem_req_rdy, mem_req_wr;
   logic [DATA_W-1:0] mem_req_addr, mem_req_data;
   logic              mem_rsp_val, mem_rsp_rdy;
   logic [DATA_W-1:0] mem_rsp_data;
   logic [$clog2(MO):0] outstanding;

   int n_tests = 0;
   int n_fail  = 0;

   falafel_mem_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MO)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_val_i(req_val), .req_rdy_o(req_rdy), .req_is_write_i(req_wr),
      .req_addr_i(req_addr), .req_data_i(req_data),
      .rsp_val_o(rsp_val), .rsp_rdy_i(rsp_rdy), .rsp_data_o(rsp_data),
      .mem_req_val_o(mem_req_val), .mem_req_rdy_i(mem_req_rdy),
      .mem_req_is_write_o(mem_req_wr), .mem_req_addr_o(mem_req_addr),
      .mem_req_data_o(mem_req_data),
      .mem_rsp_val_i(mem_rsp_val), .mem_rsp_rdy_o(mem_rsp_rdy),
      .mem_rsp_data_i(mem_rsp_data), .outstanding_o(outstanding)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who has priority, who is committed, and the order of pending responses
   int  m_rr     = 0;
   bit  m_locked = 0;
   int  m_lock_g = 0;
   int  m_q[$];

   bit  e_req_val, e_req_hs, e_rsp_hs;
   int  e_g;

   always @(negedge clk) begin : compare
      logic [N-1:0] er_rdy, er_rsp;
      bit full, empty, ersp_rdy;
      int h;
      full  = (m_q.size() == MO);
      empty = (m_q.size() == 0);
      e_g   = m_rr;
      if (m_locked) begin
         e_g = m_lock_g;
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            if (req_val[(m_rr + k) % N]) e_g = (m_rr + k) % N;
         end
      end
      h         = empty ? 0 : m_q[0];
      e_req_val = !rst && (req_val != 0) && !full;
      er_rdy    = '0;
      if (!rst && mem_req_rdy && !full) er_rdy[e_g] = 1'b1;
      er_rsp    = '0;
      if (!rst && mem_rsp_val && !empty) er_rsp[h] = 1'b1;
      ersp_rdy  = !rst && !empty && rsp_rdy[h];
      e_req_hs  = e_req_val && mem_req_rdy;
      e_rsp_hs  = ersp_rdy && mem_rsp_val;

      chk("mem_req_val", 32'(mem_req_val), 32'(e_req_val));
      chk("req_rdy", 32'(req_rdy), 32'(er_rdy));
      chk("rsp_val", 32'(rsp_val), 32'(er_rsp));
      chk("mem_rsp_rdy", 32'(mem_rsp_rdy), 32'(ersp_rdy));
      chk("rsp_data", 32'(rsp_data), 32'(mem_rsp_data));
      chk("outstanding", 32'(outstanding), rst ? 32'd0 : 32'(m_q.size()));
      if (e_req_val) begin
         chk("mem_req_addr", 32'(mem_req_addr), 32'(req_addr[e_g*DATA_W +: DATA_W]));
         chk("mem_req_data", 32'(mem_req_data), 32'(req_data[e_g*DATA_W +: DATA_W]));
         chk("mem_req_wr", 32'(mem_req_wr), 32'(req_wr[e_g]));
      end
   end

   always @(posedge clk) begin : model_update
      if (rst) begin
         m_rr     = 0;
         m_locked = 0;
         m_q      = {};
      end else begin
         if (e_rsp_hs) void'(m_q.pop_front());
         if (e_req_hs) begin
            m_q.push_back(e_g);
            m_rr     = (e_g + 1) % N;
            m_locked = 0;
         end else if (e_req_val) begin
            m_locked = 1;
            m_lock_g = e_g;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst          = 1'b1;
      req_val      = 2'b11;
      req_wr       = 2'b10;
      req_addr     = {16'hB001, 16'hA000};
      req_data     = {16'hD111, 16'hD000};
      rsp_rdy      = 2'b11;
      mem_req_rdy  = 1'b1;
      mem_rsp_val  = 1'b0;
      mem_rsp_data = 16'h0;
      step(); step();
      #1;
      chk("rst_mem_req_val", 32'(mem_req_val), 32'd0);
      chk("rst_req_rdy", 32'(req_rdy), 32'd0);
      chk("rst_outstanding", 32'(outstanding), 32'd0);

      // Alternating grants, then in-order routing of responses
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1 chk("s27_grant", 32'(req_rdy), (i % 2) ? 32'h2 : 32'h1);
         step();
      end
      #1 chk("s27_full_out", 32'(outstanding), 32'd4);
      chk("s27_full_val", 32'(mem_req_val), 32'd0);
      req_val     = 2'b00;
      mem_rsp_val = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mem_rsp_data = 16'h5000 + 16'(i);
         #1 chk("s27_route", 32'(rsp_val), (i % 2) ? 32'h2 : 32'h1);
         step();
      end
      mem_rsp_val = 1'b0;
      #1 chk("s27_drained", 32'(outstanding), 32'd0);

      // Lock holds requester 1 while memory stalls, even though requester 0 has priority
      req_val     = 2'b10;
      mem_req_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("s28_stall_rdy", 32'(req_rdy), 32'd0);
         chk("s28_stall_addr", 32'(mem_req_addr), 32'hB001);
         step();
      end
      req_val = 2'b11;
      #1 chk("s28_lock_addr", 32'(mem_req_addr), 32'hB001);
      step();
      mem_req_rdy = 1'b1;
      #1 chk("s28_hs1", 32'(req_rdy), 32'h2);
      step();
      req_val = 2'b01;
      #1 chk("s28_next0", 32'(req_rdy), 32'h1);
      step();
      req_val     = 2'b00;
      mem_rsp_val = 1'b1;
      #1 chk("s28_rsp1", 32'(rsp_val), 32'h2);
      step();
      #1 chk("s28_rsp0", 32'(rsp_val), 32'h1);
      step();
      mem_rsp_val = 1'b0;

      // Full queue blocks requests until a pop has been registered
      req_val = 2'b01;
      req_wr  = 2'b00;
      repeat (4) step();
      #1 chk("s29_out4", 32'(outstanding), 32'd4);
      chk("s29_blocked", 32'(mem_req_val), 32'd0);
      mem_rsp_val = 1'b1;
      #1 chk("s29_pop_cycle_val", 32'(mem_req_val), 32'd0);
      chk("s29_pop_rdy", 32'(mem_rsp_rdy), 32'd1);
      step();
      mem_rsp_val = 1'b0;
      #1 chk("s29_out3", 32'(outstanding), 32'd3);
      chk("s29_accept", 32'(req_rdy), 32'h1);
      step();
      #1 chk("s29_refill", 32'(outstanding), 32'd4);
      req_val     = 2'b00;
      mem_rsp_val = 1'b1;
      repeat (4) step();
      mem_rsp_val = 1'b0;
      #1 chk("s29_drained", 32'(outstanding), 32'd0);

      // Head requester not ready: response waits, then exactly one transfer
      req_val = 2'b10;
      step();
      req_val      = 2'b00;
      mem_rsp_val  = 1'b1;
      mem_rsp_data = 16'hCAFE;
      rsp_rdy      = 2'b01;
      for (int i = 0; i < 2; i++) begin
         #1 chk("s30_wait_val", 32'(rsp_val), 32'h2);
         chk("s30_wait_rdy", 32'(mem_rsp_rdy), 32'd0);
         chk("s30_data", 32'(rsp_data), 32'hCAFE);
         step();
      end
      rsp_rdy = 2'b11;
      #1 chk("s30_xfer", 32'(mem_rsp_rdy), 32'd1);
      step();
      #1 chk("s31_empty_rdy", 32'(mem_rsp_rdy), 32'd0);
      chk("s31_empty_val", 32'(rsp_val), 32'd0);
      chk("s31_empty_out", 32'(outstanding), 32'd0);
      step();
      #1 chk("s31_still_empty", 32'(outstanding), 32'd0);
      mem_rsp_val = 1'b0;

      // Reset with two outstanding and lock set
      req_val = 2'b11;
      repeat (2) step();
      req_val     = 2'b10;
      mem_req_rdy = 1'b0;
      #1 chk("s32_pre_val", 32'(mem_req_val), 32'd1);
      step();
      #1 chk("s32_pre_out", 32'(outstanding), 32'd2);
      rst = 1'b1;
      step();
      rst     = 1'b0;
      req_val = 2'b11;
      #1 chk("s32_out0", 32'(outstanding), 32'd0);
      chk("s32_prio0_addr", 32'(mem_req_addr), 32'hA000);
      mem_req_rdy = 1'b1;
      #1 chk("s32_prio0_rdy", 32'(req_rdy), 32'h1);
      step();
      req_val = 2'b00;
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/falafel_mem_arbiter.md
FALAFEL_MEM_ARBITER -- requirements
Module: falafel_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters sharing the memory port (2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4: depth of the response-routing order queue (power of two).
REQ-003 SHALL use DATA_W from falafel_pkg for all address and data widths.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 Ports SHALL be, in this order:
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  synchronous, active-high reset.
- req_val_i  in  NUM_REQ  per-requester request valid.
- req_rdy_o  out  NUM_REQ  per-requester request accepted.
- req_is_write_i  in  NUM_REQ  per-requester: 1 write, 0 read.
- req_addr_i  in  NUM_REQ x DATA_W  per-requester address.
- req_data_i  in  NUM_REQ x DATA_W  per-requester write data.
- rsp_val_o  out  NUM_REQ  per-requester response valid.
- rsp_rdy_i  in  NUM_REQ  per-requester response ready.
- rsp_data_o  out  DATA_W  response data, broadcast to all requesters.
- mem_req_val_o  out  1  memory request valid.
- mem_req_rdy_i  in  1  memory request ready.
- mem_req_is_write_o  out  1  memory request is a write.
- mem_req_addr_o  out  DATA_W  memory address.
- mem_req_data_o  out  DATA_W  memory write data.
- mem_rsp_val_i  in  1  memory response valid.
- mem_rsp_rdy_o  out  1  arbiter ready for a memory response.
- mem_rsp_data_i  in  DATA_W  memory response data.
- outstanding_o  out  clog2(MAX_OUTSTANDING)+1  current order-queue occupancy.

Function
REQ-006 A request or response transfer SHALL occur only on a cycle where both val and rdy are high.
REQ-007 Every accepted memory request, read or write, SHALL return exactly one response; responses return in request order.
REQ-008 Arbitration SHALL be round-robin from priority pointer rr_q: the winner is the first asserted req_val_i scanning rr_q, rr_q+1, ... mod NUM_REQ.
REQ-009 After a request handshake from requester g, rr_q SHALL become (g+1) mod NUM_REQ on the next cycle; otherwise rr_q holds.
REQ-010 mem_req_val_o SHALL equal (any req_val_i) && !q_full; mem_req_is_write_o, mem_req_addr_o and mem_req_data_o SHALL be muxed from the granted requester.
REQ-011 req_rdy_o[g] SHALL be mem_req_rdy_i && !q_full && (grant == g); all other bits SHALL be 0.
REQ-012 Lock: when mem_req_val_o is high and mem_req_rdy_i is low, lock_q SHALL set and the grant index SHALL be registered; while lock_q is set, the grant SHALL stay fixed regardless of other requests.
REQ-013 lock_q SHALL clear on the cycle of the memory request handshake.
REQ-014 A requester SHALL hold valid and payload stable until it is accepted.
REQ-015 Order queue: each request handshake SHALL push the grant index; each response handshake SHALL pop the head.
REQ-016 q_full SHALL be (count_q == MAX_OUTSTANDING), computed from registered state only, so no push occurs when the queue is full even if a pop happens in the same cycle.
REQ-017 A simultaneous push and pop when the queue is not full SHALL leave count_q unchanged, with both pointers advancing and wrapping mod MAX_OUTSTANDING.
REQ-018 With h = queue head, rsp_val_o[h] SHALL equal mem_rsp_val_i && !q_empty; all other bits SHALL be 0.
REQ-019 mem_rsp_rdy_o SHALL equal rsp_rdy_i[h] && !q_empty.
REQ-020 rsp_data_o SHALL equal mem_rsp_data_i combinationally.
REQ-021 If mem_rsp_val_i is high while the queue is empty, mem_rsp_rdy_o SHALL be 0, no rsp_val_o bit SHALL assert, and state SHALL be unchanged.
REQ-022 Request-to-memory and memory-to-response paths SHALL be combinational, with zero added cycles; throughput SHALL be one request per cycle.
REQ-023 outstanding_o SHALL equal count_q.

Reset
REQ-024 On rst_i high at a clock edge: rr_q=0, lock_q=0, queue pointers=0, count_q=0.
REQ-025 During reset, all outputs SHALL be driven inactive: mem_req_val_o=0, req_rdy_o=0, rsp_val_o=0, mem_rsp_rdy_o=0, outstanding_o=0.
REQ-026 Reset mid-transaction SHALL discard all outstanding routing entries; the memory side is reset together with this block.

Verification
REQ-027 Scenario: reset, then req_val_i=2'b11 with mem always ready -> grants alternate 0,1,0,1 each cycle; responses route in the same order.
REQ-028 Scenario: req 1 valid with mem_req_rdy_i=0 for 3 cycles, then req 0 asserts -> grant stays 1 until handshake; req 0 is granted next.
REQ-029 Scenario: MAX_OUTSTANDING=4, four reads accepted with no responses -> outstanding_o=4 and mem_req_val_o=0; one response popped -> the next request is accepted the following cycle.
REQ-030 Scenario: head is requester 1 with rsp_rdy_i[1]=0 and mem_rsp_val_i=1, data 0xCAFE -> rsp_val_o=2'b10, mem_rsp_rdy_o=0 until rsp_rdy_i[1]=1, then a single transfer of 0xCAFE.
REQ-031 Scenario: mem_rsp_val_i=1 with an empty queue -> mem_rsp_rdy_o=0, rsp_val_o=0, outstanding_o stays 0.
REQ-032 Scenario: rst_i asserted with 2 outstanding and lock set -> next cycle outstanding_o=0, lock cleared, requester 0 has first priority.
